// File: rtl/puf_race_pkg.sv
// Shared types and default constants for the ring-oscillator PUF race arbiter.
`timescale 1ns/1ps
package puf_race_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, RACE, RECORD, DONE} state_t;

    localparam int RESP_W_DEF         = 8;
    localparam int SEL_W_DEF          = 4;
    localparam int SETTLE_CYCLES_DEF  = 4;
    localparam int TIMEOUT_CYCLES_DEF = 2**24;
    localparam int MIN_SETTLE         = 3;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer with asynchronous active-high reset.
`timescale 1ns/1ps
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/puf_race_arbiter.sv
// Challenge sequencer / race arbiter for two RO counters; builds a RESP_W-bit PUF response.
// Optional race watchdog enabled by defining PUF_RACE_TIMEOUT_EN.
`timescale 1ns/1ps
module puf_race_arbiter
    import puf_race_pkg::*;
#(
    parameter int RESP_W         = RESP_W_DEF,
    parameter int SEL_W          = SEL_W_DEF,
    parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finished_a,
    input  logic              finished_b,
    output logic              counter_reset,
    output logic              counter_enable,
    output logic [SEL_W-1:0]  mux_sel,
    output logic [RESP_W-1:0] response,
    output logic              busy,
    output logic              done,
    output logic              tie_seen,
    output logic              timeout_err
);

    localparam int IDX_W = $clog2(RESP_W) + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;

    generate
        if (SETTLE_CYCLES < MIN_SETTLE) begin : g_settle_chk
            $error("puf_race_arbiter: SETTLE_CYCLES must be at least 3");
        end
        if ((2**SEL_W) < RESP_W) begin : g_sel_chk
            $error("puf_race_arbiter: SEL_W too narrow for RESP_W challenges");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_to_chk
            $error("puf_race_arbiter: TIMEOUT_CYCLES must be positive");
        end
    endgenerate

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx;
    logic [SET_W-1:0]   settle_cnt;
    logic               fa_s, fb_s;
    logic               race_bit, race_tie, bit_r;

    sync_2ff u_sync_a (.clk(clk), .reset(reset), .d(finished_a), .q(fa_s));
    sync_2ff u_sync_b (.clk(clk), .reset(reset), .d(finished_b), .q(fb_s));

`ifdef PUF_RACE_TIMEOUT_EN
    localparam int RC_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [RC_W-1:0] race_cnt;
    logic            race_to;
`endif

    assign counter_reset  = (state != RACE);
    assign counter_enable = (state == RACE);
    assign done           = (state == DONE);
    assign mux_sel        = SEL_W'(idx);

    always_comb begin
        state_next = state;
        race_bit   = 1'b0;
        race_tie   = 1'b0;
`ifdef PUF_RACE_TIMEOUT_EN
        race_to    = 1'b0;
`endif
        case (state)
            IDLE:   if (start) state_next = CLEAR;
            CLEAR:  if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) state_next = RACE;
            RACE: begin
                // A tie records 0; a winner outranks a watchdog expiry in the same cycle.
                if (fa_s || fb_s) begin
                    race_bit   = fa_s & ~fb_s;
                    race_tie   = fa_s & fb_s;
                    state_next = RECORD;
                end
`ifdef PUF_RACE_TIMEOUT_EN
                else if (race_cnt == RC_W'(TIMEOUT_CYCLES - 1)) begin
                    race_to    = 1'b1;
                    state_next = RECORD;
                end
`endif
            end
            RECORD: state_next = (idx == IDX_W'(RESP_W - 1)) ? DONE : CLEAR;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            bit_r      <= 1'b0;
            response   <= '0;
            busy       <= 1'b0;
            tie_seen   <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= (state == CLEAR) ? settle_cnt + SET_W'(1) : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        response <= '0;
                        tie_seen <= 1'b0;
                        idx      <= '0;
                        busy     <= 1'b1;
                    end
                end
                RACE: begin
                    bit_r <= race_bit;
                    if (race_tie) tie_seen <= 1'b1;
                end
                RECORD: begin
                    for (int k = 0; k < RESP_W; k++) begin
                        if (idx == IDX_W'(k)) response[k] <= bit_r;
                    end
                    if (idx != IDX_W'(RESP_W - 1)) idx <= idx + IDX_W'(1);
                end
                DONE:    busy <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef PUF_RACE_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            race_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            race_cnt <= (state == RACE) ? race_cnt + RC_W'(1) : '0;
            if (state == IDLE && start) timeout_err <= 1'b0;
            else if (race_to)          timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_puf_race_arbiter.sv
// Directed, table-driven bench for puf_race_arbiter (RESP_W=8, SETTLE_CYCLES=4, TIMEOUT_CYCLES=16).
`timescale 1ns/1ps
module tb_puf_race_arbiter;

    localparam int RESP_W = 8;
    localparam int SEL_W  = 4;
    localparam logic [1:0] CA = 2'd0, CB = 2'd1, CT = 2'd2, CN = 2'd3;

    logic              clk = 1'b0;
    logic              reset, start, finished_a, finished_b;
    logic              counter_reset, counter_enable, busy, done, tie_seen, timeout_err;
    logic [SEL_W-1:0]  mux_sel;
    logic [RESP_W-1:0] response;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] codes;
        int          stale_hold;
        int          poke_at;
        logic [7:0]  exp_resp;
        logic        exp_tie;
    } run_t;

    run_t runs[4];

    puf_race_arbiter #(
        .RESP_W(RESP_W), .SEL_W(SEL_W), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .finished_a(finished_a), .finished_b(finished_b),
        .counter_reset(counter_reset), .counter_enable(counter_enable),
        .mux_sel(mux_sel), .response(response), .busy(busy), .done(done),
        .tie_seen(tie_seen), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(1));
    endtask

    task automatic wait_enable(input string name);
        int n = 0;
        while (counter_enable !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check(name, 32'(counter_enable), 32'(1));
    endtask

    // Plays the role of both RO counters for one challenge.
    task automatic race(input int i, input logic [1:0] code, input int stale_hold, input bit poke);
        int n;
        int cnt;
        if (poke) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        wait_enable($sformatf("race%0d_enable", i));
        check($sformatf("race%0d_mux_sel", i), 32'(mux_sel), 32'(i));
        cnt = 1;
        repeat (i % 3) begin
            step();
            if (counter_enable) cnt++;
        end
        finished_a = (code == CA) || (code == CT);
        finished_b = (code == CB) || (code == CT);
        n = 0;
        while (counter_enable === 1'b1 && n < 200) begin
            step();
            n++;
            if (counter_enable) cnt++;
        end
        check($sformatf("race%0d_ended", i), 32'(counter_enable), 32'(0));
        if (code == CN) check($sformatf("race%0d_timeout_cycles", i), 32'(cnt), 32'(16));
        repeat (stale_hold) step();
        finished_a = 1'b0;
        finished_b = 1'b0;
    endtask

    task automatic finish_run(input string name, input logic [7:0] exp_resp, input logic exp_tie,
                              input logic exp_to, input bit poke_done);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({name, "_done_seen"}, 32'(done), 32'(1));
        check({name, "_busy_in_done"}, 32'(busy), 32'(1));
        if (poke_done) start = 1'b1;
        step();
        start = 1'b0;
        check({name, "_done_pulse"}, 32'(done), 32'(0));
        check({name, "_busy_after"}, 32'(busy), 32'(0));
        check({name, "_response"}, 32'(response), 32'(exp_resp));
        check({name, "_tie_seen"}, 32'(tie_seen), 32'(exp_tie));
        check({name, "_timeout_err"}, 32'(timeout_err), 32'(exp_to));
        if (poke_done) begin
            repeat (4) step();
            check({name, "_start_in_done_ignored"}, 32'({busy, counter_reset, counter_enable}), 32'(3'b010));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        finished_a = 1'b0;
        finished_b = 1'b0;
        repeat (3) step();
        check("rst_counter_reset", 32'(counter_reset), 32'(1));
        check("rst_counter_enable", 32'(counter_enable), 32'(0));
        check("rst_mux_sel", 32'(mux_sel), 32'(0));
        check("rst_response", 32'(response), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_tie_seen", 32'(tie_seen), 32'(0));
        check("rst_timeout_err", 32'(timeout_err), 32'(0));
        reset = 1'b0;
        step();

        // codes are {race7 .. race0}
        runs[0] = '{codes: {CB, CA, CB, CA, CB, CA, CB, CA}, stale_hold: 0, poke_at: -1,
                    exp_resp: 8'h55, exp_tie: 1'b0};
        runs[1] = '{codes: {CA, CA, CA, CA, CT, CA, CA, CA}, stale_hold: 0, poke_at: -1,
                    exp_resp: 8'hF7, exp_tie: 1'b1};
        runs[2] = '{codes: {CB, CA, CB, CB, CA, CA, CB, CA}, stale_hold: 2, poke_at: -1,
                    exp_resp: 8'h4D, exp_tie: 1'b0};
        runs[3] = '{codes: {CA, CB, CA, CB, CA, CA, CB, CB}, stale_hold: 0, poke_at: 4,
                    exp_resp: 8'hAC, exp_tie: 1'b0};

        for (int r = 0; r < 4; r++) begin
            pulse_start();
            for (int i = 0; i < RESP_W; i++) begin
                race(i, runs[r].codes[2*i +: 2], (i < RESP_W - 1) ? runs[r].stale_hold : 0,
                     runs[r].poke_at == i);
            end
            finish_run($sformatf("run%0d", r), runs[r].exp_resp, runs[r].exp_tie, 1'b0, 1'b0);
        end

        // start asserted during the DONE cycle
        pulse_start();
        for (int i = 0; i < RESP_W; i++) race(i, (i % 2 == 0) ? CA : CB, 0, 1'b0);
        finish_run("donepoke", 8'h55, 1'b0, 1'b0, 1'b1);

        // reset in the middle of challenge 5
        pulse_start();
        for (int i = 0; i < 5; i++) race(i, CA, 0, 1'b0);
        wait_enable("abort_race5_enable");
        check("abort_mux_sel_before", 32'(mux_sel), 32'(5));
        reset = 1'b1;
        #1;
        check("abort_counter_reset", 32'(counter_reset), 32'(1));
        check("abort_counter_enable", 32'(counter_enable), 32'(0));
        check("abort_mux_sel", 32'(mux_sel), 32'(0));
        check("abort_response", 32'(response), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_tie_seen", 32'(tie_seen), 32'(0));
        step();
        reset = 1'b0;
        step();
        pulse_start();
        check("restart_response_clear", 32'(response), 32'(0));
        for (int i = 0; i < RESP_W; i++) race(i, (i % 2 == 0) ? CA : CB, 0, 1'b0);
        finish_run("restart", 8'h55, 1'b0, 1'b0, 1'b0);

`ifdef PUF_RACE_TIMEOUT_EN
        pulse_start();
        race(0, CA, 0, 1'b0);
        race(1, CB, 0, 1'b0);
        race(2, CN, 0, 1'b0);
        for (int i = 3; i < RESP_W; i++) race(i, CA, 0, 1'b0);
        finish_run("timeout", 8'hF9, 1'b0, 1'b1, 1'b0);
`else
        begin
            bit left = 1'b0;
            pulse_start();
            wait_enable("hang_race0_enable");
            repeat (300) begin
                step();
                if (busy !== 1'b1 || counter_enable !== 1'b1) left = 1'b1;
            end
            check("hang_busy_stays", 32'(left), 32'(0));
            check("hang_timeout_err", 32'(timeout_err), 32'(0));
            reset = 1'b1;
            step();
            reset = 1'b0;
            step();
            check("hang_recovered_idle", 32'({busy, counter_reset}), 32'(2'b01));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
